// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: widths, arbiter state
// and the writeback request payload carried through the load FIFO.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef enum logic {WB_NORMAL, WB_DRAIN} wb_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between execute/memory stages, decode scoreboard queries and
// the RF write port. Forwarding signals exist only when WB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(parameter int XLEN = 32);
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid, mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      chk_a1, chk_a2;
  logic            busy1, busy2;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
`ifdef WB_FWD_EN
  logic            fwd1_hit, fwd2_hit;
  logic [XLEN-1:0] fwd_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, chk_a1, chk_a2,
    input  alu_ready, mem_ready, busy1, busy2, we3, a3, wd3
`ifdef WB_FWD_EN
    , input fwd1_hit, fwd2_hit, fwd_data
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, chk_a1, chk_a2,
    output alu_ready, mem_ready, busy1, busy2, we3, a3, wd3
`ifdef WB_FWD_EN
    , output fwd1_hit, fwd2_hit, fwd_data
`endif
  );
endinterface

// File: rtl/wb_fifo.sv
// Power-of-two FIFO for buffered load results; the caller never pushes while full
// and never pops while empty.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;

  assign dout  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writebacks onto the single RF write port, with a busy
// scoreboard for decode stalls. Define WB_FWD_EN to add the write-edge bypass.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave wb
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  wb_state_t         state_q, state_d;
  logic              alu_fire, mem_fire, pop, full, empty, win_vld;
  logic [CW-1:0]     count, count_nxt;
  logic [$bits(wb_req_t)-1:0] head_raw;
  wb_req_t           head, win;
  logic              we3_q;
  logic [REG_AW-1:0] a3_q;
  logic [XLEN-1:0]   wd3_q;
  logic [NREG-1:0]   busy_q, busy_set, busy_clr;
  logic              hit1, hit2;

  assign wb.alu_ready = (state_q == WB_NORMAL);
  assign wb.mem_ready = !full;
  assign alu_fire     = wb.alu_valid && wb.alu_ready;
  assign mem_fire     = wb.mem_valid && !full;
  assign head         = wb_req_t'(head_raw);

  wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_req_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (mem_fire),
    .pop   (pop),
    .din   ({wb.mem_rd, wb.mem_data}),
    .dout  (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    win_vld   = 1'b0;
    win       = head;
    count_nxt = '0;
    case (state_q)
      WB_NORMAL: begin
        pop     = !empty && !alu_fire;
        win_vld = alu_fire || pop;
        if (alu_fire) win = '{rd: wb.alu_rd, data: wb.alu_data};
      end
      WB_DRAIN: begin
        pop     = !empty;
        win_vld = pop;
      end
      default: ;
    endcase
    count_nxt = count + CW'(mem_fire) - CW'(pop);
    case (state_q)
      WB_NORMAL: if (count_nxt == CW'(FIFO_DEPTH)) state_d = WB_DRAIN;
      WB_DRAIN:  if (count_nxt == '0)              state_d = WB_NORMAL;
      default:   state_d = WB_NORMAL;
    endcase
  end

  // rd==0 still wins the port and consumes its slot; only the RF strobe is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_NORMAL;
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      we3_q   <= win_vld && (win.rd != '0);
      if (win_vld) begin
        a3_q  <= win.rd;
        wd3_q <= win.data;
      end
    end
  end

  assign wb.we3 = we3_q;
  assign wb.a3  = a3_q;
  assign wb.wd3 = wd3_q;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (wb.iss_valid) busy_set[wb.iss_rd] = 1'b1;
    busy_set[0] = 1'b0;
    if (we3_q) busy_clr[a3_q] = 1'b1;
  end

  // OR-ing the set after the clear makes a same-cycle issue win over retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= (busy_q & ~busy_clr) | busy_set;
  end

`ifdef WB_FWD_EN
  assign hit1        = we3_q && (a3_q != '0) && (a3_q == wb.chk_a1);
  assign hit2        = we3_q && (a3_q != '0) && (a3_q == wb.chk_a2);
  assign wb.fwd1_hit = hit1;
  assign wb.fwd2_hit = hit2;
  assign wb.fwd_data = wd3_q;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign wb.busy1 = busy_q[wb.chk_a1] && !hit1;
  assign wb.busy2 = busy_q[wb.chk_a2] && !hit2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: a behavioural model predicts every RF
// write into a queue that a monitor drains; scenario tasks check handshakes and busy bits.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(32)) wb ();

  regfile_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t exp_q[$];
  ent_t mf[$];
  bit   m_drain;
  bit   m_aa, m_ma, m_pp;
  ent_t m_e, mon_e;

  // Reference arbiter: samples the inputs the DUT sees at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      mf.delete();
      m_drain = 1'b0;
    end else begin
      m_aa = wb.alu_valid && !m_drain;
      m_ma = wb.mem_valid && (mf.size() != DEPTH);
      m_pp = (mf.size() != 0) && (m_drain || !m_aa);
      if (m_aa) begin
        if (wb.alu_rd != 5'd0) exp_q.push_back('{rd: wb.alu_rd, data: wb.alu_data});
      end else if (m_pp) begin
        if (mf[0].rd != 5'd0) exp_q.push_back(mf[0]);
      end
      if (m_pp) m_e = mf.pop_front();
      if (m_ma) mf.push_back('{rd: wb.mem_rd, data: wb.mem_data});
      if (!m_drain && mf.size() == DEPTH) m_drain = 1'b1;
      else if (m_drain && mf.size() == 0) m_drain = 1'b0;
    end
  end

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (wb.we3 !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_we3: got %0b want %0b", wb.we3, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (wb.we3) begin
          checks++;
          if (wb.a3 !== mon_e.rd || wb.wd3 !== mon_e.data) begin
            errors++;
            $display("FAIL sb_write: got a3=%0d wd3=%h want a3=%0d wd3=%h",
                     wb.a3, wb.wd3, mon_e.rd, mon_e.data);
          end
        end
      end
      checks++;
      if (wb.alu_ready !== !m_drain || wb.mem_ready !== (mf.size() != DEPTH)) begin
        errors++;
        $display("FAIL sb_ready: got alu=%0b mem=%0b want alu=%0b mem=%0b",
                 wb.alu_ready, wb.mem_ready, !m_drain, mf.size() != DEPTH);
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.mem_valid = 1'b0; wb.mem_rd = '0; wb.mem_data = '0;
    wb.iss_valid = 1'b0; wb.iss_rd = '0;
    wb.chk_a1 = '0; wb.chk_a2 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    checks++;
    if ({wb.we3, wb.a3, wb.wd3} !== '0) begin
      errors++; $display("FAIL reset_wport: got we3=%0b a3=%0d wd3=%h want 0", wb.we3, wb.a3, wb.wd3);
    end
    checks++;
    if ({wb.busy1, wb.busy2} !== 2'b00) begin
      errors++; $display("FAIL reset_busy: got %b want 00", {wb.busy1, wb.busy2});
    end
    checks++;
    if ({wb.alu_ready, wb.mem_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b want 11", {wb.alu_ready, wb.mem_ready});
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_alu_basic();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'h1234;
    cyc();
    wb.alu_valid = 1'b0;
    checks++;
    if (wb.we3 !== 1'b1 || wb.a3 !== 5'd5 || wb.wd3 !== 32'h1234) begin
      errors++; $display("FAIL alu_write: got we3=%0b a3=%0d wd3=%h want 1/5/1234", wb.we3, wb.a3, wb.wd3);
    end
    cyc();
    checks++;
    if (wb.we3 !== 1'b0 || wb.a3 !== 5'd5 || wb.wd3 !== 32'h1234) begin
      errors++; $display("FAIL alu_hold: got we3=%0b a3=%0d wd3=%h want 0/5/1234", wb.we3, wb.a3, wb.wd3);
    end
  endtask

  task automatic test_scoreboard();
    wb.chk_a1 = 5'd7; wb.chk_a2 = 5'd0;
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd7;
    cyc();
    wb.iss_valid = 1'b0;
    checks++;
    if (wb.busy1 !== 1'b1 || wb.busy2 !== 1'b0) begin
      errors++; $display("FAIL sb_set: got busy1=%0b busy2=%0b want 1/0", wb.busy1, wb.busy2);
    end
    wb.mem_valid = 1'b1; wb.mem_rd = 5'd7; wb.mem_data = 32'hCAFE;
    cyc();
    wb.mem_valid = 1'b0;
    checks++;
    if (wb.busy1 !== 1'b1 || wb.we3 !== 1'b0) begin
      errors++; $display("FAIL sb_queued: got busy1=%0b we3=%0b want 1/0", wb.busy1, wb.we3);
    end
    cyc();
    checks++;
    if (wb.we3 !== 1'b1 || wb.a3 !== 5'd7 || wb.wd3 !== 32'hCAFE || wb.busy1 !== 1'b1) begin
      errors++; $display("FAIL sb_load_wr: got we3=%0b a3=%0d wd3=%h busy1=%0b want 1/7/cafe/1",
                         wb.we3, wb.a3, wb.wd3, wb.busy1);
    end
    cyc();
    checks++;
    if (wb.busy1 !== 1'b0) begin
      errors++; $display("FAIL sb_clear: got busy1=%0b want 0", wb.busy1);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      wb.alu_valid = 1'b1; wb.alu_rd = 5'(10 + i); wb.alu_data = 32'hA000 + 32'(i);
      wb.mem_valid = 1'b1; wb.mem_rd = 5'(20 + i); wb.mem_data = 32'hB000 + 32'(i);
      cyc();
    end
    wb.mem_valid = 1'b0;
    wb.alu_rd = 5'd30; wb.alu_data = 32'hC0DE;
    checks++;
    if (wb.alu_ready !== 1'b0 || wb.mem_ready !== 1'b0 || wb.a3 !== 5'd13) begin
      errors++; $display("FAIL drain_enter: got alu_rdy=%0b mem_rdy=%0b a3=%0d want 0/0/13",
                         wb.alu_ready, wb.mem_ready, wb.a3);
    end
    cyc(DEPTH);
    checks++;
    if (wb.alu_ready !== 1'b1 || wb.we3 !== 1'b1 || wb.a3 !== 5'd23 || wb.wd3 !== 32'hB003) begin
      errors++; $display("FAIL drain_exit: got alu_rdy=%0b we3=%0b a3=%0d wd3=%h want 1/1/23/b003",
                         wb.alu_ready, wb.we3, wb.a3, wb.wd3);
    end
    cyc();
    wb.alu_valid = 1'b0;
    checks++;
    if (wb.we3 !== 1'b1 || wb.a3 !== 5'd30) begin
      errors++; $display("FAIL drain_resume: got we3=%0b a3=%0d want 1/30", wb.we3, wb.a3);
    end
    cyc();
  endtask

  task automatic test_rd_zero();
    wb.chk_a1 = 5'd12; wb.chk_a2 = 5'd0;
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd12;
    cyc();
    wb.iss_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'hFFFF;
    checks++;
    if (wb.alu_ready !== 1'b1) begin
      errors++; $display("FAIL rd0_ready: got %0b want 1", wb.alu_ready);
    end
    cyc();
    wb.alu_valid = 1'b0;
    checks++;
    if (wb.we3 !== 1'b0 || wb.busy1 !== 1'b1 || wb.busy2 !== 1'b0) begin
      errors++; $display("FAIL rd0_suppress: got we3=%0b busy1=%0b busy2=%0b want 0/1/0",
                         wb.we3, wb.busy1, wb.busy2);
    end
  endtask

  task automatic test_set_wins();
    wb.chk_a1 = 5'd9;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'h99;
    cyc();
    wb.alu_valid = 1'b0;
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd9;
    checks++;
    if (wb.we3 !== 1'b1 || wb.a3 !== 5'd9) begin
      errors++; $display("FAIL setwin_wr: got we3=%0b a3=%0d want 1/9", wb.we3, wb.a3);
    end
    cyc();
    wb.iss_valid = 1'b0;
    checks++;
    if (wb.busy1 !== 1'b1) begin
      errors++; $display("FAIL setwin_busy: got %0b want 1", wb.busy1);
    end
  endtask

  task automatic test_reset_mid();
    wb.chk_a1 = 5'd14;
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd14;
    cyc();
    wb.iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd15; wb.alu_data = 32'hD000 + 32'(i);
      wb.mem_valid = 1'b1; wb.mem_rd = 5'(16 + i); wb.mem_data = 32'hE000 + 32'(i);
      cyc();
    end
    idle();
    wb.chk_a1 = 5'd14;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wb.we3 !== 1'b0 || wb.a3 !== 5'd0 || wb.busy1 !== 1'b0 ||
        wb.alu_ready !== 1'b1 || wb.mem_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_clear: got we3=%0b a3=%0d busy1=%0b alu_rdy=%0b mem_rdy=%0b want 0/0/0/1/1",
                         wb.we3, wb.a3, wb.busy1, wb.alu_ready, wb.mem_ready);
    end
    #4 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if (wb.we3 !== 1'b0) begin
        errors++; $display("FAIL rstmid_stale: cycle %0d got we3=%0b a3=%0d want we3=0", i, wb.we3, wb.a3);
      end
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    wb.chk_a1 = 5'd3; wb.chk_a2 = 5'd4;
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd3;
    cyc();
    wb.iss_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'h3333;
    cyc();
    wb.alu_valid = 1'b0;
    checks++;
    if (wb.fwd1_hit !== 1'b1 || wb.fwd2_hit !== 1'b0 || wb.fwd_data !== 32'h3333 || wb.busy1 !== 1'b0) begin
      errors++; $display("FAIL fwd_hit: got h1=%0b h2=%0b data=%h busy1=%0b want 1/0/3333/0",
                         wb.fwd1_hit, wb.fwd2_hit, wb.fwd_data, wb.busy1);
    end
    cyc();
    checks++;
    if (wb.fwd1_hit !== 1'b0 || wb.busy1 !== 1'b0) begin
      errors++; $display("FAIL fwd_after: got h1=%0b busy1=%0b want 0/0", wb.fwd1_hit, wb.busy1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_basic();
    test_scoreboard();
    test_drain();
    test_rd_zero();
    test_set_wins();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
